inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//   IF stage of the expye pipeline. Owns the PC and drives the combinational
//   instruction memory (addr/ce -> inst, same cycle). Captures {pc, inst} pairs
//   into a small prefetch queue and hands them to the IF/ID register over a
//   valid/ready handshake. Absorbs decode stalls and flushes on branch/jump redirect.
// PARAMETERS
//   ADDR_W       32   PC / instruction address width (matches `InstAddrBus)
//   INST_W       32   instruction width (matches `InstBus)
//   QUEUE_DEPTH  2    prefetch queue entries; power of 2, >= 2
//   RESET_PC     32'h0000_0000   PC value loaded on reset
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous reset, active-high
//   inst_addr_o    out  ADDR_W  address to inst_mem (= current pc)
//   inst_mem_ce    out  1       inst_mem chip enable
//   inst_data_i    in   INST_W  instruction from inst_mem, valid same cycle as addr
//   redirect_i     in   1       branch/jump taken, from EX
//   redirect_pc_i  in   ADDR_W  redirect target
//   id_valid_o     out  1       queue head valid towards IF/ID
//   id_ready_i     in   1       IF/ID accepts head this cycle
//   id_pc_o        out  ADDR_W  pc of head entry
//   id_inst_o      out  INST_W  instruction of head entry
// BEHAVIOUR
//   - Reset (async, rst=1): pc=RESET_PC, inst_mem_ce=0, queue empty, id_valid_o=0,
//     id_pc_o=0, id_inst_o=0 (`ZeroWord). Reset mid-operation discards all entries.
//   - First cycle after rst falls: ce_q<=1 on the clock edge; fetch starts the cycle after.
//   - inst_addr_o = pc always; inst_mem_ce = ce_q (registered).
//   - push = ce_q & ~redirect_i & (~full | pop). On push: enqueue {pc, inst_data_i},
//     pc <= pc + 4 (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0). Latency pc -> id_valid_o: 1 cycle.
//   - pop = id_valid_o & id_ready_i; head advances on the edge. id_valid_o = ~empty.
//   - Full and pop in same cycle: push still proceeds (no bubble).
//   - Full and no pop: no push; pc holds; inst_mem_ce stays 1 (re-read is harmless).
//   - Empty and id_ready_i=1: id_valid_o=0; no underflow, pointers unchanged.
//   - Redirect (priority over push and pop): queue flushed (count=0), pc <=
//     {redirect_pc_i[ADDR_W-1:2], 2'b00}; the current inst_data_i is dropped; the
//     target is fetched the next cycle and valid at id 1 cycle after that.
//   - Back-to-back redirects: the last one wins; each flushes again.
//   - id_pc_o/id_inst_o hold their value while id_valid_o=1 & id_ready_i=0.
//   - Counter: occupancy width clog2(QUEUE_DEPTH)+1; pointers wrap modulo QUEUE_DEPTH.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: extra port fetch_cnt_o out 32 = number of pushes
//     since reset (wraps at 2^32; reset 0) plus flush_cnt_o out 32 = number of
//     redirects (reset 0).
//   FETCH_PERF_CNT_EN undefined: neither port nor counters exist; otherwise identical.
// STRUCTURE
//   - Shared macros.v: `InstAddrBus, `InstBus, `ZeroWord, `RstEnable, `ChipEnable,
//     `ChipDisable, `PcStep (32'd4).
//   - Sub-module fetch_queue: synchronous FIFO (push/pop/flush, full/empty,
//     {pc,inst} payload), parameterised by QUEUE_DEPTH. The PC/ce logic stays in
//     inst_fetch_unit.
// TESTING
//   1. Reset release, id_ready_i=1 -> inst_mem_ce=1 one cycle after; id_pc_o
//      sequence 0x0,0x4,0x8 on consecutive cycles with matching inst words.
//   2. id_ready_i=0 for 5 cycles -> queue holds 2 entries (pc 0x0,0x4), pc frozen
//      at 0x8; on id_ready_i=1, 0x0,0x4,0x8 out with no gap or duplicate.
//   3. redirect_i=1, redirect_pc_i=0x100 while queue full -> id_valid_o=0 next
//      cycle, then id_pc_o=0x100, 0x104; stale 0x8 never appears.
//   4. redirect_pc_i=0x103 -> fetch address 0x100.
//   5. RESET_PC=32'hFFFF_FFF8 -> id_pc_o FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6. rst asserted mid-stream with 2 entries queued -> id_valid_o=0 and
//      inst_mem_ce=0 immediately (before next edge); with FETCH_PERF_CNT_EN, fetch_cnt_o=0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants for the instruction fetch stage
package inst_fetch_unit_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam int          INST_W_DEF  = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// rtl/inst_fetch_unit_fetch_queue.sv - prefetch FIFO holding {pc, inst} pairs
// Output reads as zero while empty so the IF/ID side sees clean zeros.
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - IF stage: PC, inst_mem drive, prefetch queue, redirect flush
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o / flush_cnt_o performance counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W      = INST_ADDR_W,
  parameter int              INST_W      = INST_W_DEF,
  parameter int              QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_mem_ce,
  input  logic [INST_W-1:0] inst_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  logic [ADDR_W-1:0]        pc;
  logic                     ce_q;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+INST_W-1:0] head;

  assign inst_addr_o = pc;
  assign inst_mem_ce = ce_q;
  assign id_valid_o  = ~empty;
  assign pop         = id_valid_o & id_ready_i;
  assign push        = ce_q & ~redirect_i & (~full | pop);
  assign id_pc_o     = head[ADDR_W+INST_W-1:INST_W];
  assign id_inst_o   = head[INST_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      ce_q <= 1'b0;
    end else begin
      ce_q <= 1'b1;
      if (redirect_i)
        pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      else if (push)
        pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (ADDR_W + INST_W)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({pc, inst_data_i}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (push)       fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (redirect_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b0;
  logic [31:0] addr;
  logic        ce;
  logic [31:0] inst;
  logic        valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        rst_b = 1'b1;
  logic [31:0] addr_b;
  logic        ce_b;
  logic [31:0] inst_b;
  logic        valid_b;
  logic [31:0] id_pc_b;
  logic [31:0] id_inst_b;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] fetch_cnt_b;
  logic [31:0] flush_cnt_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + a[7:0] + 16'h1234};
  endfunction

  assign inst   = mem_word(addr);
  assign inst_b = mem_word(addr_b);

  inst_fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .inst_addr_o(addr), .inst_mem_ce(ce), .inst_data_i(inst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .id_valid_o(valid),
    .id_ready_i(ready), .id_pc_o(id_pc), .id_inst_o(id_inst)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  inst_fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst_b), .inst_addr_o(addr_b), .inst_mem_ce(ce_b), .inst_data_i(inst_b),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .id_valid_o(valid_b),
    .id_ready_i(1'b1), .id_pc_o(id_pc_b), .id_inst_o(id_inst_b)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_b), .flush_cnt_o(flush_cnt_b)
`endif
  );

  // Reference model: a fetch PC, an enable flag and a queue of fetched {pc, inst}.
  logic [31:0] m_pc = 32'h0;
  bit          m_ce = 1'b0;
  logic [63:0] m_q[$];
  logic [31:0] m_fetches = 0;
  logic [31:0] m_flushes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ce = 1'b0;
    m_q.delete();
    m_fetches = 0;
    m_flushes = 0;
  endtask

  task automatic model_step();
    bit did_pop;
    if (rst) begin
      model_reset();
      return;
    end
    did_pop = (m_q.size() > 0) && ready;
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_flushes++;
    end else begin
      if (did_pop) void'(m_q.pop_front());
      if (m_ce && m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
        m_fetches++;
      end
    end
    m_ce = 1'b1;
  endtask

  task automatic compare_all();
    check("id_valid", 64'(valid), 64'(m_q.size() != 0));
    check("id_pc", 64'(id_pc), (m_q.size() != 0) ? 64'(m_q[0][63:32]) : 64'h0);
    check("id_inst", 64'(id_inst), (m_q.size() != 0) ? 64'(m_q[0][31:0]) : 64'h0);
    check("inst_addr", 64'(addr), 64'(m_pc));
    check("inst_mem_ce", 64'(ce), 64'(m_ce));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetches));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
`endif
  endtask

  // Inputs are already set by the caller at posedge+1.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    cycle();
    cycle();

    // Reset release with ready high: streaming 0x0, 0x4, 0x8 ...
    rst = 1'b0;
    ready = 1'b1;
    repeat (5) cycle();

    // Stall: queue fills to DEPTH, pc freezes, then drains without gaps.
    ready = 1'b0;
    repeat (5) cycle();
    ready = 1'b1;
    repeat (4) cycle();

    // Redirect while full.
    ready = 1'b0;
    repeat (4) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    ready = 1'b1;
    repeat (4) cycle();

    // Unaligned target and back-to-back redirects.
    redirect = 1'b1;
    redirect_pc = 32'h103;
    cycle();
    check("unaligned_target", 64'(addr), 64'h100);
    redirect_pc = 32'h2002;
    cycle();
    redirect = 1'b0;
    repeat (3) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom();
      if (i % 50 == 49) redirect_pc = 32'hFFFF_FFF9;
      cycle();
    end
    redirect = 1'b0;

    // Asynchronous reset with entries queued.
    ready = 1'b0;
    repeat (4) cycle();
    check("full_before_rst", 64'(valid), 64'h1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(valid), 64'h0);
    check("async_rst_ce", 64'(ce), 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("async_rst_fetch_cnt", 64'(fetch_cnt), 64'h0);
`endif
    model_reset();
    cycle();
    rst = 1'b0;
    ready = 1'b1;
    repeat (4) cycle();

    // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0000_0000.
    check("wrap_rst_valid", 64'(valid_b), 64'h0);
    check("wrap_rst_addr", 64'(addr_b), 64'(WRAP_PC));
    rst_b = 1'b0;
    @(negedge clk);
    check("wrap_ce_off", 64'(ce_b), 64'h0);
    @(negedge clk);
    check("wrap_ce_on", 64'(ce_b), 64'h1);
    check("wrap_not_yet_valid", 64'(valid_b), 64'h0);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = WRAP_PC + 32'(4 * k);
      @(negedge clk);
      check("wrap_valid", 64'(valid_b), 64'h1);
      check("wrap_pc", 64'(id_pc_b), 64'(exp_pc));
      check("wrap_inst", 64'(id_inst_b), 64'(mem_word(exp_pc)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
